// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: two requester channels plus the shared BRAM port
interface bram_port_arbiter_if #(
    parameter int ADDR_BITS = 12,
    parameter int DATA_BITS = 16
);
    logic                 a_req, a_we, a_lock, a_ack, a_rvalid;
    logic [ADDR_BITS-1:0] a_addr;
    logic [DATA_BITS-1:0] a_wdata, a_rdata;
    logic                 b_req, b_we, b_lock, b_ack, b_rvalid;
    logic [ADDR_BITS-1:0] b_addr;
    logic [DATA_BITS-1:0] b_wdata, b_rdata;
    logic                 mem_rd_en, mem_wr_en;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata, mem_rdata;

    modport slave (
        input  a_req, a_we, a_lock, a_addr, a_wdata,
        input  b_req, b_we, b_lock, b_addr, b_wdata,
        input  mem_rdata,
        output a_ack, a_rvalid, a_rdata,
        output b_ack, b_rvalid, b_rdata,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );

    modport master (
        output a_req, a_we, a_lock, a_addr, a_wdata,
        output b_req, b_we, b_lock, b_addr, b_wdata,
        output mem_rdata,
        input  a_ack, a_rvalid, a_rdata,
        input  b_ack, b_rvalid, b_rdata,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin arbiter with bounded lock sharing one BRAM port between two requesters
module bram_port_arbiter #(
    parameter int NUM_BLOCKS = 16,
    parameter int SEL_BITS   = $clog2(NUM_BLOCKS),
    parameter int ADDR_BITS  = SEL_BITS + 8,
    parameter int DATA_BITS  = 16,
    parameter int MAX_HOLD   = 8
) (
    input logic clk,
    input logic reset,
    bram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE_A, ISSUE_B} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

    state_t               state;
    owner_t               lock_owner;
    logic                 rr_b;
    logic [7:0]           hold_cnt, hold_next;
    logic                 a_held, b_held, a_elig, b_elig;
    logic                 grant_a, grant_b, grant, sel_we, sel_lock, forced;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [DATA_BITS-1:0] sel_wdata;

    // a lock only holds while its owner keeps the lock input high
    assign a_held    = lock_owner == OWN_A && bus.a_lock;
    assign b_held    = lock_owner == OWN_B && bus.b_lock;
    assign a_elig    = bus.a_req && state != ISSUE_A && !b_held;
    assign b_elig    = bus.b_req && state != ISSUE_B && !a_held;
    assign grant_a   = a_elig && (!b_elig || !rr_b);
    assign grant_b   = b_elig && !grant_a;
    assign grant     = grant_a || grant_b;
    assign sel_we    = grant_a ? bus.a_we : bus.b_we;
    assign sel_lock  = grant_a ? bus.a_lock : bus.b_lock;
    assign sel_addr  = grant_a ? bus.a_addr : bus.b_addr;
    assign sel_wdata = grant_a ? bus.a_wdata : bus.b_wdata;
    assign hold_next = (((grant_a && a_held) || (grant_b && b_held)) ? hold_cnt : 8'd0) + 8'd1;
    assign forced    = grant && sel_lock && hold_next == 8'(MAX_HOLD);
    assign bus.a_rdata = bus.a_rvalid ? bus.mem_rdata : '0;
    assign bus.b_rdata = bus.b_rvalid ? bus.mem_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            lock_owner    <= OWN_NONE;
            rr_b          <= 1'b0;
            hold_cnt      <= 8'd0;
            bus.a_ack     <= 1'b0;
            bus.b_ack     <= 1'b0;
            bus.a_rvalid  <= 1'b0;
            bus.b_rvalid  <= 1'b0;
            bus.mem_rd_en <= 1'b0;
            bus.mem_wr_en <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state         <= grant_a ? ISSUE_A : grant_b ? ISSUE_B : IDLE;
            bus.a_ack     <= grant_a;
            bus.b_ack     <= grant_b;
            bus.mem_rd_en <= grant && !sel_we;
            bus.mem_wr_en <= grant && sel_we;
            // the ack register doubles as the owner bit of the one-deep read pipeline
            bus.a_rvalid  <= bus.a_ack && bus.mem_rd_en;
            bus.b_rvalid  <= bus.b_ack && bus.mem_rd_en;
            if (grant) begin
                bus.mem_addr  <= sel_addr;
                bus.mem_wdata <= sel_wdata;
                rr_b          <= grant_a;
            end
            if (forced) begin
                lock_owner <= OWN_NONE;
                hold_cnt   <= 8'd0;
            end else if (grant && sel_lock) begin
                lock_owner <= grant_a ? OWN_A : OWN_B;
                hold_cnt   <= hold_next;
            end else if (grant || (lock_owner != OWN_NONE && !a_held && !b_held)) begin
                lock_owner <= OWN_NONE;
                hold_cnt   <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed checks of arbitration order, lock, read routing and reset
module tb_bram_port_arbiter;
    typedef struct {
        logic        we;
        logic        lock;
        logic [11:0] addr;
        logic [15:0] wdata;
    } op_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = '0;
    logic [15:0] poke_data = '0;
    logic [15:0] bram [0:4095];
    logic [15:0] refm [0:4095];
    op_t qa[$];
    op_t qb[$];
    byte log_q[$];
    int vectors = 0;
    int miscompares = 0;
    logic exp_av = 1'b0, exp_bv = 1'b0;
    logic [15:0] exp_ad = '0, exp_bd = '0;

    always #5 clk = ~clk;

    bram_port_arbiter_if #(.ADDR_BITS(12), .DATA_BITS(16)) bus ();
    bram_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    always @(posedge clk) begin
        if (poke_en) bram[poke_addr] <= poke_data;
        if (bus.mem_wr_en) bram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd_en) bus.mem_rdata <= bram[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic op_t mk(input logic we, input logic lock, input logic [11:0] addr, input logic [15:0] wdata);
        op_t o;
        o.we = we;
        o.lock = lock;
        o.addr = addr;
        o.wdata = wdata;
        return o;
    endfunction

    task automatic drive();
        bus.a_req   = qa.size() != 0;
        bus.a_we    = qa.size() != 0 ? qa[0].we : 1'b0;
        bus.a_lock  = qa.size() != 0 ? qa[0].lock : 1'b0;
        bus.a_addr  = qa.size() != 0 ? qa[0].addr : '0;
        bus.a_wdata = qa.size() != 0 ? qa[0].wdata : '0;
        bus.b_req   = qb.size() != 0;
        bus.b_we    = qb.size() != 0 ? qb[0].we : 1'b0;
        bus.b_lock  = qb.size() != 0 ? qb[0].lock : 1'b0;
        bus.b_addr  = qb.size() != 0 ? qb[0].addr : '0;
        bus.b_wdata = qb.size() != 0 ? qb[0].wdata : '0;
    endtask

    task automatic poke(input logic [11:0] addr, input logic [15:0] data);
        poke_en = 1'b1;
        poke_addr = addr;
        poke_data = data;
        refm[addr] = data;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic do_ack(input logic is_a);
        op_t op;
        if ((is_a ? qa.size() : qb.size()) == 0) begin
            chk(is_a ? "spurious_a_ack" : "spurious_b_ack", 1, 0);
        end else begin
            if (is_a) op = qa.pop_front(); else op = qb.pop_front();
            chk("mem_rd_en", bus.mem_rd_en, !op.we);
            chk("mem_wr_en", bus.mem_wr_en, op.we);
            chk("mem_addr", bus.mem_addr, op.addr);
            if (op.we) begin
                chk("mem_wdata", bus.mem_wdata, op.wdata);
                refm[op.addr] = op.wdata;
            end else if (is_a) begin
                exp_av = 1'b1;
                exp_ad = refm[op.addr];
            end else begin
                exp_bv = 1'b1;
                exp_bd = refm[op.addr];
            end
            log_q.push_back(is_a ? byte'("A") : byte'("B"));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("a_rvalid", bus.a_rvalid, exp_av);
        if (exp_av) chk("a_rdata", bus.a_rdata, exp_ad);
        chk("b_rvalid", bus.b_rvalid, exp_bv);
        if (exp_bv) chk("b_rdata", bus.b_rdata, exp_bd);
        exp_av = 1'b0;
        exp_bv = 1'b0;
        chk("both_strobes", bus.mem_rd_en & bus.mem_wr_en, 0);
        chk("both_acks", bus.a_ack & bus.b_ack, 0);
        if (!bus.a_ack && !bus.b_ack) chk("idle_strobe", bus.mem_rd_en | bus.mem_wr_en, 0);
        if (bus.a_ack) do_ack(1'b1);
        if (bus.b_ack) do_ack(1'b0);
        drive();
    endtask

    task automatic run(input int budget);
        int n = 0;
        drive();
        while ((qa.size() != 0 || qb.size() != 0 || exp_av || exp_bv) && n < budget) begin
            step();
            n++;
        end
        chk("timeout", qa.size() != 0 || qb.size() != 0 || exp_av || exp_bv, 0);
    endtask

    task automatic check_order(input string exp);
        chk("order_len", log_q.size(), exp.len());
        for (int i = 0; i < exp.len(); i++)
            chk($sformatf("order%0d", i), i < log_q.size() ? log_q[i] : 8'd0, exp[i]);
        log_q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_flags"}, {bus.a_ack, bus.b_ack, bus.a_rvalid, bus.b_rvalid, bus.mem_rd_en, bus.mem_wr_en}, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_rdata"}, {bus.a_rdata, bus.b_rdata}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        qa.delete();
        qb.delete();
        drive();
        exp_av = 1'b0;
        exp_bv = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_zero("rst");
        @(negedge clk);
        reset = 1'b0;
        log_q.delete();
    endtask

    initial begin
        // basic read of a pre-loaded word
        do_reset();
        poke(12'h105, 16'hBEEF);
        qa.push_back(mk(1'b0, 1'b0, 12'h105, 16'h0));
        run(20);
        check_order("A");

        // continuous contention alternates; B sees A's write
        do_reset();
        for (int i = 0; i < 3; i++) begin
            qa.push_back(mk(1'b1, 1'b0, 12'h010, 16'h1234));
            qb.push_back(mk(1'b0, 1'b0, 12'h010, 16'h0));
        end
        run(40);
        check_order("ABABAB");

        // B locked burst of three writes blocks A
        do_reset();
        for (int i = 0; i < 3; i++)
            qb.push_back(mk(1'b1, 1'b1, 12'h200 + 12'(i), 16'hB001 + 16'(i)));
        drive();
        step();
        qa.push_back(mk(1'b0, 1'b0, 12'h200, 16'h0));
        qa.push_back(mk(1'b0, 1'b0, 12'h201, 16'h0));
        run(40);
        check_order("BBBAA");

        // hold limit forces the lock off after MAX_HOLD accesses
        do_reset();
        for (int i = 0; i < 12; i++)
            qa.push_back(mk(1'b1, i < 9, 12'h300 + 12'(i), 16'hA000 + 16'(i)));
        for (int i = 0; i < 4; i++)
            qb.push_back(mk(1'b0, 1'b0, 12'h300 + 12'(i), 16'h0));
        run(100);
        check_order("AAAAAAAABABABABA");

        // reset between ack and rvalid drops the read
        do_reset();
        qa.push_back(mk(1'b0, 1'b0, 12'h105, 16'h0));
        drive();
        step();
        chk("mid_ack_seen", log_q.size(), 1);
        reset = 1'b1;
        exp_av = 1'b0;
        qa.delete();
        drive();
        #1 check_zero("async_rst");
        @(posedge clk);
        #1 check_zero("held_rst");
        @(negedge clk);
        reset = 1'b0;
        log_q.delete();
        qa.push_back(mk(1'b0, 1'b0, 12'h105, 16'h0));
        qb.push_back(mk(1'b0, 1'b0, 12'h105, 16'h0));
        run(20);
        check_order("AB");

        // B alone reading across the word-address wrap
        do_reset();
        poke(12'h0FF, 16'h1111);
        poke(12'h000, 16'h2222);
        qb.push_back(mk(1'b0, 1'b0, 12'h0FF, 16'h0));
        qb.push_back(mk(1'b0, 1'b0, 12'h000, 16'h0));
        run(20);
        check_order("BB");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
